// File: rtl/message_buffer_if.sv
// rtl/message_buffer_if.sv - receive/printer signal bundle for message_buffer
interface message_buffer_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              new_rx_data;
  logic              reverse;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic [ADDR_W-1:0] msg_len;
  logic              msg_ready;
  logic              msg_done;
  logic              overflow;

  modport master (
    output rx_data, new_rx_data, reverse, addr, msg_done,
    input  data, msg_len, msg_ready, overflow
  );

  modport slave (
    input  rx_data, new_rx_data, reverse, addr, msg_done,
    output data, msg_len, msg_ready, overflow
  );
endinterface

// File: rtl/message_buffer.sv
// rtl/message_buffer.sv - DEPTH-slot receive message store with forward/reverse printer readout
module message_buffer #(
  parameter int         DEPTH     = 8,
  parameter int         ADDR_W    = 4,
  parameter int         BIN_MODE  = 1,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input logic              clk,
  input logic              rst,
  message_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);
  localparam int                SLOTS   = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              overflow_q, overflow_d;
  logic              reverse_q;
  logic              store_en;
  logic [7:0]        store_char;
  logic [7:0]        data_q, rd_char;
  logic [ADDR_W-1:0] rd_idx;

  // Sized to the full address space so len/addr index it without width games;
  // slots at or above DEPTH are never written and stay constant zero.
  logic [7:0]        slot_q [SLOTS];

  assign store_char = (BIN_MODE != 0) ? (bus.rx_data[0] ? 8'h31 : 8'h30) : bus.rx_data;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    store_en   = 1'b0;
    case (state_q)
      S_EMPTY, S_FILL: begin
        if (bus.new_rx_data) begin
          if (bus.rx_data == TERM_CHAR) begin
            if (len_q != '0) state_d = S_READY;
          end else begin
            store_en = 1'b1;
            len_d    = len_q + ADDR_W'(1);
            state_d  = (len_d == DEPTH_L) ? S_READY : S_FILL;
          end
        end
      end
      S_READY: begin
        if (bus.new_rx_data) overflow_d = 1'b1;
        if (bus.msg_done) begin
          state_d = S_EMPTY;
          len_d   = '0;
        end
      end
      default: begin
        state_d = S_EMPTY;
        len_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      len_q      <= '0;
      overflow_q <= 1'b0;
      reverse_q  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
      // Order is frozen at whatever reverse showed on the completing edge.
      if (state_q != S_READY) reverse_q <= bus.reverse;
      if (store_en) slot_q[len_q] <= store_char;
    end
  end

  // Index subtraction only matters when addr < len, so it cannot underflow there.
  always_comb begin
    rd_idx  = reverse_q ? (len_q - ADDR_W'(1) - bus.addr) : bus.addr;
    rd_char = 8'h20;
    if (bus.addr < len_q)                     rd_char = slot_q[rd_idx];
    else if (bus.addr == len_q)               rd_char = 8'h0A;
    else if (bus.addr == len_q + ADDR_W'(1))  rd_char = 8'h0D;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= rd_char;
  end

  assign bus.data      = data_q;
  assign bus.msg_len   = len_q;
  assign bus.msg_ready = (state_q == S_READY);
  assign bus.overflow  = overflow_q;

endmodule
